// File: rtl/clk_sched_pkg.sv
// Shared types, reset constants and config validity check for the clock-enable scheduler.
// CntW sets the width of every period/high/count field; the top-level CNT_W must match it.
package clk_sched_pkg;

  localparam int unsigned CntW = 16;

  typedef struct packed {
    logic            en;
    logic [CntW-1:0] period;
    logic [CntW-1:0] high;
  } ch_cfg_t;

  localparam logic [CntW-1:0] RstPeriod = CntW'(2);
  localparam logic [CntW-1:0] RstHigh   = CntW'(1);
  localparam ch_cfg_t         RstCfg    = '{en: 1'b0, period: RstPeriod, high: RstHigh};

  // A period needs at least one high and one low cycle.
  function automatic logic cfg_is_valid(logic [CntW-1:0] period, logic [CntW-1:0] high);
    return (period >= CntW'(2)) && (high != '0) && (high < period);
  endfunction

endpackage

// File: rtl/clk_sched_ctrl_if.sv
// Configuration port of clk_sched_ctrl: valid/ready request carrying channel, period,
// high time and enable, plus the one-cycle reject pulse returned by the scheduler.
//   master: requester (drives cfg_valid/cfg_ch/cfg_period/cfg_high/cfg_en)
//   slave : scheduler (drives cfg_ready/cfg_err)
interface clk_sched_ctrl_if #(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned CNT_W  = 16
) ();
  localparam int unsigned ChW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [ChW-1:0]   cfg_ch;
  logic [CNT_W-1:0] cfg_period;
  logic [CNT_W-1:0] cfg_high;
  logic             cfg_en;
  logic             cfg_err;

  modport master (
    output cfg_valid, cfg_ch, cfg_period, cfg_high, cfg_en,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_period, cfg_high, cfg_en,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/clk_sched_channel.sv
// One scheduler channel: active and shadow config, period counter and registered outputs.
// Ports:
//   clock_i, reset_ni   system clock, async active-low reset
//   wr_i, wr_cfg_i      accepted config write into the shadow registers
//   align_i             force apply of pending shadow and restart of the count
//   pending_o           shadow waiting for a period boundary
//   clk_out_o           derived clock, high while cnt < high
//   rise_pulse_o        high in the first cycle of each enabled period
module clk_sched_channel
  import clk_sched_pkg::*;
(
  input  logic    clock_i,
  input  logic    reset_ni,
  input  logic    wr_i,
  input  ch_cfg_t wr_cfg_i,
  input  logic    align_i,
  output logic    pending_o,
  output logic    clk_out_o,
  output logic    rise_pulse_o
);

  ch_cfg_t         act_q, act_d, shd_q, shd_d;
  logic            pend_q, pend_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            clk_q, clk_d, rise_q, rise_d;
  logic            last, apply;

  always_comb begin
    last   = act_q.en && (cnt_q == act_q.period - CntW'(1));
    // A disabled channel is at a boundary every cycle.
    apply  = pend_q && (last || !act_q.en || align_i);
    act_d  = act_q;
    shd_d  = shd_q;
    pend_d = pend_q;
    cnt_d  = (act_q.en && !last) ? cnt_q + CntW'(1) : '0;
    if (apply) begin
      act_d  = shd_q;
      pend_d = 1'b0;
    end
    if (align_i) cnt_d = '0;
    // Writes only happen while not pending, so they never collide with an apply.
    if (wr_i) begin
      shd_d  = wr_cfg_i;
      pend_d = 1'b1;
    end
    if (!act_d.en) cnt_d = '0;
    // Outputs are computed from next state so they stay in step with cnt.
    clk_d  = act_d.en && (cnt_d < act_d.high);
    rise_d = act_d.en && (cnt_d == '0);
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      act_q  <= RstCfg;
      shd_q  <= RstCfg;
      pend_q <= 1'b0;
      cnt_q  <= '0;
      clk_q  <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      act_q  <= act_d;
      shd_q  <= shd_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      clk_q  <= clk_d;
      rise_q <= rise_d;
    end
  end

  assign pending_o    = pend_q;
  assign clk_out_o    = clk_q;
  assign rise_pulse_o = rise_q;

endmodule

// File: rtl/clk_sched_ctrl.sv
// Multi-channel clock-enable scheduler: decodes the shared config port, runs the
// handshake and reject pulse, and fans the align strobe out to every channel.
// Ports:
//   clock_i, reset_ni   system clock, async active-low reset
//   cfg                 config port (clk_sched_ctrl_if.slave)
//   align_i             phase-align strobe, present only with CLK_SCHED_ALIGN_EN defined
//   pending_o           per-channel shadow waiting for boundary
//   clk_out_o           per-channel derived clock
//   rise_pulse_o        per-channel period start pulse
module clk_sched_ctrl
  import clk_sched_pkg::*;
#(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned CNT_W  = CntW
) (
  input  logic              clock_i,
  input  logic              reset_ni,
  clk_sched_ctrl_if.slave   cfg,
`ifdef CLK_SCHED_ALIGN_EN
  input  logic              align_i,
`endif
  output logic [NUM_CH-1:0] pending_o,
  output logic [NUM_CH-1:0] clk_out_o,
  output logic [NUM_CH-1:0] rise_pulse_o
);

  localparam int unsigned ChW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              ch_ok, xfer, cfg_ok, err_q, align;
  logic [NUM_CH-1:0] wr;
  logic [CNT_W-1:0]  period, high;
  ch_cfg_t           wr_cfg;

`ifdef CLK_SCHED_ALIGN_EN
  assign align = align_i;
`else
  assign align = 1'b0;
`endif

  assign period = cfg.cfg_period;
  assign high   = cfg.cfg_high;

  always_comb begin
    ch_ok         = 1'b0;
    cfg.cfg_ready = 1'b1;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (cfg.cfg_ch == ChW'(i)) begin
        ch_ok         = 1'b1;
        cfg.cfg_ready = ~pending_o[i];
      end
    end
  end

  assign xfer   = cfg.cfg_valid && cfg.cfg_ready;
  assign cfg_ok = ch_ok && cfg_is_valid(period, high);

  always_comb begin
    wr_cfg = '{en: cfg.cfg_en, period: period, high: high};
    wr     = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      wr[i] = xfer && cfg_ok && (cfg.cfg_ch == ChW'(i));
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) err_q <= 1'b0;
    else           err_q <= xfer && !cfg_ok;
  end

  assign cfg.cfg_err = err_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_sched_channel u_ch (
      .clock_i      (clock_i),
      .reset_ni     (reset_ni),
      .wr_i         (wr[g]),
      .wr_cfg_i     (wr_cfg),
      .align_i      (align),
      .pending_o    (pending_o[g]),
      .clk_out_o    (clk_out_o[g]),
      .rise_pulse_o (rise_pulse_o[g])
    );
  end

endmodule

// File: tb/tb_clk_sched_ctrl.sv
// Directed bench for clk_sched_ctrl; align checks are built when CLK_SCHED_ALIGN_EN is defined.
module tb_clk_sched_ctrl;

  logic       clock;
  logic       reset_n;
  logic [2:0] pending, clk_out, rise;
`ifdef CLK_SCHED_ALIGN_EN
  logic       align;
`endif

  int n_checks = 0;
  int n_errors = 0;

  clk_sched_ctrl_if #(.NUM_CH(3), .CNT_W(16)) cfg_if ();

  clk_sched_ctrl #(.NUM_CH(3), .CNT_W(16)) dut (
    .clock_i      (clock),
    .reset_ni     (reset_n),
    .cfg          (cfg_if),
`ifdef CLK_SCHED_ALIGN_EN
    .align_i      (align),
`endif
    .pending_o    (pending),
    .clk_out_o    (clk_out),
    .rise_pulse_o (rise)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic valid, input logic [1:0] ch, input logic en,
                       input logic [15:0] period, input logic [15:0] high);
    cfg_if.cfg_valid  = valid;
    cfg_if.cfg_ch     = ch;
    cfg_if.cfg_en     = en;
    cfg_if.cfg_period = period;
    cfg_if.cfg_high   = high;
  endtask

  logic [18:0] pat1;
  logic [6:0]  pat2;
  bit          found;

  initial begin
    reset_n = 1'b0;
`ifdef CLK_SCHED_ALIGN_EN
    align = 1'b0;
`endif
    drive(1'b0, 2'd0, 1'b0, 16'd0, 16'd0);
    tick();
    tick();
    check("rst_clk_out", 32'(clk_out), 32'h0);
    check("rst_rise", 32'(rise), 32'h0);
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_ready", 32'(cfg_if.cfg_ready), 32'h1);
    check("rst_err", 32'(cfg_if.cfg_err), 32'h0);
    reset_n = 1'b1;
    tick();

    // ch0 {period 4, high 1} from disabled: pending one cycle, then 1000 repeating.
    drive(1'b1, 2'd0, 1'b1, 16'd4, 16'd1);
    check("ch0_ready", 32'(cfg_if.cfg_ready), 32'h1);
    tick();
    cfg_if.cfg_valid = 1'b0;
    check("ch0_pending", 32'(pending[0]), 32'h1);
    check("ch0_clk_pre", 32'(clk_out[0]), 32'h0);
    tick();
    check("ch0_pending_clr", 32'(pending[0]), 32'h0);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("ch0_clk_%0d", k), 32'(clk_out[0]), 32'((k % 4) == 0));
      check($sformatf("ch0_rise_%0d", k), 32'(rise[0]), 32'((k % 4) == 0));
      tick();
    end

    // ch1 {10,5}, reprogrammed to {3,2} at cnt 3: full old period, then 110.
    drive(1'b1, 2'd1, 1'b1, 16'd10, 16'd5);
    tick();
    cfg_if.cfg_valid = 1'b0;
    tick();
    pat1 = 19'b1111100000110110110;
    for (int i = 0; i < 19; i++) begin
      if (i == 4) begin
        check("ch1_pend_set", 32'(pending[1]), 32'h1);
        check("ch1_ready_low", 32'(cfg_if.cfg_ready), 32'h0);
        cfg_if.cfg_valid = 1'b0;
      end
      if (i == 9) check("ch1_pend_hold", 32'(pending[1]), 32'h1);
      if (i == 10) begin
        check("ch1_pend_clr", 32'(pending[1]), 32'h0);
        check("ch1_rise_new", 32'(rise[1]), 32'h1);
      end
      check($sformatf("ch1_clk_%0d", i), 32'(clk_out[1]), 32'(pat1[18-i]));
      if (i == 3) drive(1'b1, 2'd1, 1'b1, 16'd3, 16'd2);
      tick();
    end

    // Rejected requests: high == period, period < 2 / high == 0, channel out of range.
    drive(1'b1, 2'd2, 1'b1, 16'd5, 16'd5);
    check("rej1_ready", 32'(cfg_if.cfg_ready), 32'h1);
    tick();
    cfg_if.cfg_valid = 1'b0;
    check("rej1_err", 32'(cfg_if.cfg_err), 32'h1);
    check("rej1_pend", 32'(pending[2]), 32'h0);
    tick();
    check("rej1_err_clr", 32'(cfg_if.cfg_err), 32'h0);
    drive(1'b1, 2'd2, 1'b1, 16'd1, 16'd0);
    tick();
    cfg_if.cfg_valid = 1'b0;
    check("rej2_err", 32'(cfg_if.cfg_err), 32'h1);
    tick();
    check("rej2_err_clr", 32'(cfg_if.cfg_err), 32'h0);
    check("rej2_clk", 32'(clk_out[2]), 32'h0);
    drive(1'b1, 2'd3, 1'b1, 16'd4, 16'd2);
    check("rej3_ready", 32'(cfg_if.cfg_ready), 32'h1);
    tick();
    cfg_if.cfg_valid = 1'b0;
    check("rej3_err", 32'(cfg_if.cfg_err), 32'h1);
    check("rej3_pend", 32'(pending), 32'h0);
    tick();
    check("rej3_err_clr", 32'(cfg_if.cfg_err), 32'h0);

    // Back-to-back to ch2: second request stalls while the first is pending.
    drive(1'b1, 2'd2, 1'b1, 16'd4, 16'd2);
    tick();
    drive(1'b1, 2'd2, 1'b1, 16'd6, 16'd3);
    check("b2b_pend1", 32'(pending[2]), 32'h1);
    check("b2b_ready_low", 32'(cfg_if.cfg_ready), 32'h0);
    tick();
    check("b2b_pend_clr", 32'(pending[2]), 32'h0);
    check("b2b_ready_hi", 32'(cfg_if.cfg_ready), 32'h1);
    check("b2b_clk_a0", 32'(clk_out[2]), 32'h1);
    tick();
    cfg_if.cfg_valid = 1'b0;
    check("b2b_pend2", 32'(pending[2]), 32'h1);
    check("b2b_clk_a1", 32'(clk_out[2]), 32'h1);
    tick();
    check("b2b_clk_a2", 32'(clk_out[2]), 32'h0);
    tick();
    check("b2b_clk_a3", 32'(clk_out[2]), 32'h0);
    tick();
    check("b2b_pend2_clr", 32'(pending[2]), 32'h0);
    check("b2b_rise_b", 32'(rise[2]), 32'h1);
    pat2 = 7'b1110001;
    for (int i = 0; i < 7; i++) begin
      check($sformatf("b2b_clk_b%0d", i), 32'(clk_out[2]), 32'(pat2[6-i]));
      tick();
    end

    // Reset in the high phase of ch0 {6,3} with a ch1 config pending.
    drive(1'b1, 2'd0, 1'b1, 16'd6, 16'd3);
    tick();
    cfg_if.cfg_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (!pending[0] && rise[0]) found = 1'b1;
      else tick();
    end
    check("rst_mid_apply_seen", 32'(found), 32'h1);
    check("rst_mid_clk0", 32'(clk_out[0]), 32'h1);
    tick();
    drive(1'b1, 2'd1, 1'b1, 16'd3, 16'd1);
    tick();
    cfg_if.cfg_valid = 1'b0;
    check("rst_mid_pend1", 32'(pending[1]), 32'h1);
    check("rst_mid_clk2", 32'(clk_out[0]), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_async_clk", 32'(clk_out), 32'h0);
    check("rst_async_pend", 32'(pending), 32'h0);
    check("rst_async_rise", 32'(rise), 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("post_rst_clk_%0d", i), 32'(clk_out), 32'h0);
      check($sformatf("post_rst_pend_%0d", i), 32'(pending), 32'h0);
    end

`ifdef CLK_SCHED_ALIGN_EN
    drive(1'b1, 2'd0, 1'b1, 16'd4, 16'd2);
    tick();
    drive(1'b1, 2'd1, 1'b1, 16'd6, 16'd3);
    tick();
    cfg_if.cfg_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    align = 1'b1;
    tick();
    align = 1'b0;
    check("align_rise", 32'(rise[1:0]), 32'h3);
    for (int k = 0; k < 12; k++) begin
      check($sformatf("align_clk0_%0d", k), 32'(clk_out[0]), 32'((k % 4) < 2));
      check($sformatf("align_clk1_%0d", k), 32'(clk_out[1]), 32'((k % 6) < 3));
      tick();
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/clk_sched_ctrl.md
# clk_sched_ctrl

Synthesizable multi-channel clock-enable scheduler that replaces free-running testbench clock loops with register-programmed, cycle-accurate derived clocks. Each channel produces a periodic output with a programmable period and high time in units of the system clock. A valid/ready configuration port updates channels glitch-free, applying new settings only at period boundaries. It sits between the control/register layer and any logic that needs divided or duty-cycled clocks or enables.

## Interface
- NUM_CH, 3, number of independent output channels (1..8)
- CNT_W, 16, width of period/high-time counters
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- cfg_valid  in  1  configuration request
- cfg_ready  out  1  configuration accepted when high with cfg_valid
- cfg_ch  in  $clog2(NUM_CH) (min 1)  target channel
- cfg_period  in  CNT_W  period in clock cycles
- cfg_high  in  CNT_W  high time in clock cycles
- cfg_en  in  1  channel enable to apply
- cfg_err  out  1  one-cycle pulse: transferred config rejected
- pending  out  NUM_CH  per channel: shadow config waiting for boundary
- clk_out  out  NUM_CH  derived clock per channel, registered
- rise_pulse  out  NUM_CH  one-cycle pulse on each clk_out rising cycle
- align  in  1  phase-align strobe (only with CLK_SCHED_ALIGN_EN)

## Operation
- Per channel, active registers: en, period, high, cnt. Shadow registers: s_en, s_period, s_high, pending.
- Transfer when cfg_valid && cfg_ready. cfg_ready = ~pending[cfg_ch]; cfg_ch >= NUM_CH gives cfg_ready = 1.
- Reject, with cfg_err pulsed next cycle and no state change, when: cfg_ch >= NUM_CH, cfg_period < 2, cfg_high == 0, or cfg_high >= cfg_period. Rejected transfers still complete the handshake.
- Accepted config is written to the shadow registers, and pending is set next cycle.
- Apply shadow → active, and clear pending, in the cycle after a boundary cycle.
  - Boundary cycle: the channel is enabled and cnt == period-1, or the channel is disabled (any cycle).
  - On apply, cnt = 0.
- Enabled channel: cnt counts 0..period-1 and wraps. clk_out = (cnt < high).
- rise_pulse = en && cnt == 0.
- Disabled channel: cnt held at 0, clk_out = 0, rise_pulse = 0.
- Channels are fully independent. Only the config port is shared.

## Timing
- Reset values:
  - cnt = 0, en = 0, period = 2, high = 1
  - clk_out = 0, rise_pulse = 0, pending = 0, cfg_err = 0
  - cfg_ready = 1
  - shadows = reset actives
- clk_out and cnt are registered and update together. Per enabled period, clk_out is high for exactly `high` cycles, then low for `period-high` cycles.
- Disabled channel: a transfer at cycle t sets pending at t+1. Apply happens at t+2, where cnt = 0 and clk_out = 1 (if enabled), with rise_pulse = 1.
- Enabled channel: the new settings take effect in the cycle after cnt == period-1. No truncated or stretched period is ever output.
- Transfer in the same cycle as a boundary: pending is not yet set, so the apply waits for the next boundary.
- Reset asserted mid-period: all outputs go to reset values immediately (asynchronous). Pending configs are discarded.

## Configuration
- CLK_SCHED_ALIGN_EN
  - Defined: align port exists. align high at cycle t causes every channel to apply its pending shadow (if any) and set cnt = 0 at t+1. Enabled channels give rise_pulse at t+1. align overrides boundary timing.
  - Undefined: no align port. Phase is set only by each channel's own apply.

## Structure
- Package clk_sched_pkg holds:
  - the CNT_W default
  - a typedef for the channel config struct {en, period, high}
  - the reset constants (period = 2, high = 1)
  - the validity-check function
- Sub-module clk_sched_channel: active/shadow registers, counter and output for one channel. It is instantiated NUM_CH times.
- The top level holds the config decode, handshake, cfg_err and align fan-out.

## Test plan
- Reset, then program ch0 {en=1, period=4, high=1} → pending[0] high 1 cycle; clk_out[0] pattern 1000 repeating; rise_pulse[0] every 4 cycles.
- ch1 running {period=10, high=5}; at cnt=3 send {period=3, high=2} → ch1 completes the 10-cycle period (5 high, 5 low), then shows 110 repeating. cfg_ready for ch1 is low while pending.
- Send {period=5, high=5} and {period=1, high=0} → cfg_err pulses once per request, handshake completes, clk_out unchanged.
- Two back-to-back configs to ch2 while pending → second held with cfg_ready = 0 until pending[2] clears, then accepted.
- Deassert reset_n mid-high phase of ch0 {period=6, high=3} → clk_out = 0 and pending = 0 immediately; after release, outputs stay low until reprogrammed.
- With CLK_SCHED_ALIGN_EN: ch0 {period=4, high=2} and ch1 {period=6, high=3} free-running; pulse align → both rise_pulse asserted in the same cycle, then patterns restart from cnt = 0.
